if_fetch_ctrl: RTL

Sequencer for the instruction-fetch stage: owns the program counter, issues single-outstanding read requests to a multi-cycle instruction memory over a req/ack handshake, and buffers one fetched instruction for the IF/ID pipeline register. It applies downstream stall (hazard freeze) and branch redirects. Requests already on the bus when a branch arrives are completed and discarded, never abandoned.

---
 rtl/if_fetch_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch sequencer.
// Owns the PC, keeps one read outstanding to a multi-cycle instruction memory over a req/ack
// handshake, and buffers one fetched instruction for the IF/ID register. Downstream stall
// freezes the buffer; a branch redirects the PC. A request that is already on the bus when a
// branch arrives is completed and its data dropped (KILL state), never abandoned.
//
// Optional feature: define IF_FETCH_TIMEOUT_EN to add a request-wait counter. When a request
// waits TIMEOUT cycles without ack, fetch_err is set (sticky) and the block parks in ERR until
// reset. Without the macro there is no counter, no ERR state and fetch_err is tied low.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        fetch_err
);

`ifdef IF_FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StKill  = 2'd2,
    StErr   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StKill  = 2'd2
  } state_e;
`endif

  // A zero timeout would make every request fail before memory can answer.
  if (TIMEOUT == 0) begin : gen_timeout_chk
    $error("if_fetch_ctrl: TIMEOUT must be non-zero");
  end

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] kill_addr_q;
  logic        instr_valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;

  logic        xfer;
  logic        timeout_hit;

  // Request is combinational so a freed buffer slot is refilled in the same cycle.
  always_comb begin
    mem_req = 1'b0;
    unique case (state_q)
      StFetch: mem_req = !instr_valid_q || !stall_in;
      StKill:  mem_req = 1'b1;
      default: mem_req = 1'b0;
    endcase
  end

  // While killing, keep presenting the old address until memory answers it.
  assign mem_addr = (state_q == StKill) ? kill_addr_q : pc_q;

  assign xfer = mem_req && mem_ack;

`ifdef IF_FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;
  logic            waiting;

  assign waiting     = mem_req && !mem_ack;
  assign timeout_hit = waiting && !branch_taken && (cnt_q == CntW'(TIMEOUT - 1));
  assign fetch_err   = err_q;

  // Count cycles a request waits for ack; the flag stays set until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (branch_taken || mem_ack) begin
      cnt_q <= '0;
    end else if (timeout_hit) begin
      cnt_q <= '0;
      err_q <= 1'b1;
    end else if (waiting) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // Fetch FSM together with the PC and the one-entry instruction buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      kill_addr_q   <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      pc_out_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
        end

        StFetch: begin
          if (branch_taken) begin
            // Branch wins over stall and over any data returning this edge.
            instr_valid_q <= 1'b0;
            pc_q          <= branch_address;
            if (mem_req && !mem_ack) begin
              kill_addr_q <= pc_q;
              state_q     <= StKill;
            end
          end else if (timeout_hit) begin
            instr_valid_q <= 1'b0;
            state_q       <= state_e'(2'd3);
          end else if (xfer) begin
            instr_q       <= mem_rdata;
            pc_out_q      <= pc_q;
            instr_valid_q <= 1'b1;
            pc_q          <= pc_q + 32'd4;
          end else if (instr_valid_q && !stall_in) begin
            instr_valid_q <= 1'b0;
          end
        end

        StKill: begin
          // Latest branch target wins; the stale request still has to complete.
          if (branch_taken) begin
            pc_q <= branch_address;
          end
          if (mem_ack) begin
            state_q <= StFetch;
          end else if (timeout_hit) begin
            state_q <= state_e'(2'd3);
          end
        end

        default: begin
          // ERR parks here until reset; an undefined encoding recovers through IDLE.
`ifdef IF_FETCH_TIMEOUT_EN
          state_q <= state_q;
`else
          state_q <= StIdle;
`endif
        end
      endcase
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;

endmodule
